// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot controller.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXIT_RD   = 2'd1,
        EXIT_COST = 2'd2
    } state_e;

    localparam logic [1:0] ERR_CONFLICT = 2'd0;
    localparam logic [1:0] ERR_DUP      = 2'd1;
    localparam logic [1:0] ERR_FULL     = 2'd2;
    localparam logic [1:0] ERR_ABSENT   = 2'd3;

endpackage

// File: rtl/parking_tick_timer.sv
// Time base: divides clk by TICK_DIV and advances a wrapping tick counter.
module parking_tick_timer #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned TIME_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [TIME_W-1:0] time_o
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0]  div_q;
    logic [TIME_W-1:0] time_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            time_q <= '0;
        end else if (div_q == DIV_W'(TICK_DIV - 1)) begin
            div_q  <= '0;
            time_q <= time_q + TIME_W'(1);
        end else begin
            div_q  <= div_q + DIV_W'(1);
        end
    end

    assign time_o = time_q;

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: occupancy table, entry-time storage and saturating exit fee.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter  int unsigned ID_W     = 3,
    parameter  int unsigned SLOTS    = 4,
    parameter  int unsigned TIME_W   = 8,
    parameter  int unsigned COST_W   = 12,
    parameter  int unsigned RATE     = 2,
    parameter  int unsigned MIN_FEE  = 1,
    parameter  int unsigned TICK_DIV = 50_000_000,
    localparam int unsigned CNT_W    = $clog2(SLOTS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              entry,
    input  logic              exit,
    input  logic [ID_W-1:0]   car_id,
    output logic              ready,
    output logic              entry_ack,
    output logic              exit_ack,
    output logic [COST_W-1:0] ccost,
    output logic              cost_valid,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  cars_count,
    output logic              is_empty,
    output logic              is_full,
    output logic [TIME_W-1:0] current_time
);

    localparam int unsigned N_IDS  = 2 ** ID_W;
    localparam int unsigned PROD_W = TIME_W + COST_W;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [TIME_W-1:0]  dur_q, dur_d;
    logic [N_IDS-1:0]   occ_q, occ_d;
    logic [TIME_W-1:0]  tin_q [N_IDS];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [COST_W-1:0]  ccost_q, ccost_d;
    logic               ready_q, entry_ack_q, exit_ack_q, cost_valid_q, err_q;
    logic               entry_ack_d, exit_ack_d, cost_valid_d, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               is_empty_q, is_full_q;
    logic               tin_we;
    logic [PROD_W-1:0]  prod_c;
    logic [COST_W-1:0]  fee_c;
    logic [TIME_W-1:0]  time_c;

    parking_tick_timer #(
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .time_o (time_c)
    );

    // Fee is formed at full product width, floored at MIN_FEE, then saturated.
    always_comb begin
        prod_c = PROD_W'(dur_q) * PROD_W'(RATE);
        if (prod_c < PROD_W'(MIN_FEE)) begin
            prod_c = PROD_W'(MIN_FEE);
        end
        if (prod_c > PROD_W'({COST_W{1'b1}})) begin
            fee_c = '1;
        end else begin
            fee_c = prod_c[COST_W-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        dur_d        = dur_q;
        occ_d        = occ_q;
        count_d      = count_q;
        ccost_d      = ccost_q;
        entry_ack_d  = 1'b0;
        exit_ack_d   = 1'b0;
        cost_valid_d = 1'b0;
        err_d        = 1'b0;
        err_code_d   = 2'd0;
        tin_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (entry && exit) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_CONFLICT;
                end else if (entry) begin
                    if (occ_q[car_id]) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_DUP;
                    end else if (count_q == CNT_W'(SLOTS)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_FULL;
                    end else begin
                        occ_d[car_id] = 1'b1;
                        tin_we        = 1'b1;
                        count_d       = count_q + CNT_W'(1);
                        entry_ack_d   = 1'b1;
                    end
                end else if (exit) begin
                    if (!occ_q[car_id]) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ABSENT;
                    end else begin
                        id_d    = car_id;
                        state_d = EXIT_RD;
                    end
                end
            end
            EXIT_RD: begin
                // Unsigned subtraction gives the modulo-2^TIME_W duration across wrap.
                dur_d       = time_c - tin_q[id_q];
                occ_d[id_q] = 1'b0;
                count_d     = count_q - CNT_W'(1);
                state_d     = EXIT_COST;
            end
            EXIT_COST: begin
                ccost_d      = fee_c;
                cost_valid_d = 1'b1;
                exit_ack_d   = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            id_q         <= '0;
            dur_q        <= '0;
            occ_q        <= '0;
            count_q      <= '0;
            ccost_q      <= '0;
            ready_q      <= 1'b1;
            entry_ack_q  <= 1'b0;
            exit_ack_q   <= 1'b0;
            cost_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            is_empty_q   <= 1'b1;
            is_full_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            dur_q        <= dur_d;
            occ_q        <= occ_d;
            count_q      <= count_d;
            ccost_q      <= ccost_d;
            ready_q      <= (state_d == IDLE);
            entry_ack_q  <= entry_ack_d;
            exit_ack_q   <= exit_ack_d;
            cost_valid_q <= cost_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            is_empty_q   <= (count_d == '0);
            is_full_q    <= (count_d == CNT_W'(SLOTS));
        end
    end

    // Entry times carry no reset; occupancy bits qualify them.
    always_ff @(posedge clk) begin
        if (tin_we) begin
            tin_q[car_id] <= time_c;
        end
    end

    assign ready        = ready_q;
    assign entry_ack    = entry_ack_q;
    assign exit_ack     = exit_ack_q;
    assign ccost        = ccost_q;
    assign cost_valid   = cost_valid_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign cars_count   = count_q;
    assign is_empty     = is_empty_q;
    assign is_full      = is_full_q;
    assign current_time = time_c;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Scoreboard bench for parking_lot_ctrl plus a saturating-tariff instance.
module tb_parking_lot_ctrl;

    localparam int unsigned ID_W  = 3;
    localparam int unsigned SLOTS = 4;
    localparam int unsigned TIME_W = 8;
    localparam int unsigned CNT_W = 3;

    typedef struct {
        int kind;   // 0 entry ack, 1 error, 2 exit cost
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic entry = 1'b0, exit = 1'b0;
    logic [ID_W-1:0] car_id = '0;
    logic ready, entry_ack, exit_ack, cost_valid, err, is_empty, is_full;
    logic [11:0] ccost;
    logic [1:0] err_code;
    logic [CNT_W-1:0] cars_count;
    logic [TIME_W-1:0] current_time;

    logic s_entry = 1'b0, s_exit = 1'b0;
    logic [ID_W-1:0] s_id = '0;
    logic s_ready, s_entry_ack, s_exit_ack, s_cost_valid, s_err, s_is_empty, s_is_full;
    logic [7:0] s_ccost;
    logic [1:0] s_err_code;
    logic [CNT_W-1:0] s_cars_count;
    logic [TIME_W-1:0] s_current_time;

    // Reference time base and occupancy model
    logic [1:0]        mdiv;
    logic [TIME_W-1:0] mtime;
    logic [TIME_W-1:0] tin_m [8];
    logic [7:0]        occ_m = '0;
    int                cnt_m = 0;

    always #5 clk = ~clk;

    parking_lot_ctrl #(
        .ID_W(3), .SLOTS(4), .TIME_W(8), .COST_W(12), .RATE(2), .MIN_FEE(1), .TICK_DIV(4)
    ) u_dut (
        .clk(clk), .reset(reset), .entry(entry), .exit(exit), .car_id(car_id),
        .ready(ready), .entry_ack(entry_ack), .exit_ack(exit_ack), .ccost(ccost),
        .cost_valid(cost_valid), .err(err), .err_code(err_code), .cars_count(cars_count),
        .is_empty(is_empty), .is_full(is_full), .current_time(current_time)
    );

    parking_lot_ctrl #(
        .ID_W(3), .SLOTS(4), .TIME_W(8), .COST_W(8), .RATE(100), .MIN_FEE(1), .TICK_DIV(4)
    ) u_sat (
        .clk(clk), .reset(reset), .entry(s_entry), .exit(s_exit), .car_id(s_id),
        .ready(s_ready), .entry_ack(s_entry_ack), .exit_ack(s_exit_ack), .ccost(s_ccost),
        .cost_valid(s_cost_valid), .err(s_err), .err_code(s_err_code), .cars_count(s_cars_count),
        .is_empty(s_is_empty), .is_full(s_is_full), .current_time(s_current_time)
    );

    always @(posedge clk) begin
        if (reset) begin
            mdiv  <= 2'd0;
            mtime <= '0;
        end else if (mdiv == 2'd3) begin
            mdiv  <= 2'd0;
            mtime <= mtime + 8'd1;
        end else begin
            mdiv  <= mdiv + 2'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fee(input int d, input int rate, input int cost_w);
        int p;
        int cap;
        p   = d * rate;
        cap = (1 << cost_w) - 1;
        if (p < 1) p = 1;
        if (p > cap) p = cap;
        return p;
    endfunction

    // Every response pulse on the main DUT consumes one scoreboard entry.
    always @(negedge clk) begin : monitor
        int   n, k, v;
        exp_t e;
        if (!reset) begin
            n = int'(entry_ack) + int'(err) + int'(cost_valid);
            if (exit_ack || cost_valid) check_eq("ack_vs_valid", 32'(exit_ack), 32'(cost_valid));
            if (n > 1) check_eq("multi_pulse", 32'(n), 32'd1);
            if (n == 1) begin
                k = entry_ack ? 0 : (err ? 1 : 2);
                v = err ? int'(err_code) : (cost_valid ? int'(ccost) : 0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pulse", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_kind", 32'(k), 32'(e.kind));
                    check_eq("sb_val", 32'(v), 32'(e.val));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Wait until the model time reaches t right after a tick boundary.
    task automatic wait_time(input logic [TIME_W-1:0] t);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (mtime == t && mdiv == 2'd0) break;
            tick();
        end
        if (i == 3000) check_eq("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_entry(input int id);
        entry  = 1'b1;
        car_id = 3'(id);
        if (occ_m[id]) begin
            push(1, 1);
        end else if (cnt_m == SLOTS) begin
            push(1, 2);
        end else begin
            push(0, 0);
            occ_m[id] = 1'b1;
            tin_m[id] = mtime;
            cnt_m++;
        end
        tick();
        entry = 1'b0;
        check_eq("entry_count", 32'(cars_count), 32'(cnt_m));
        check_eq("entry_ready", 32'(ready), 32'd1);
    endtask

    task automatic do_exit(input int id);
        logic [TIME_W-1:0] d;
        exit   = 1'b1;
        car_id = 3'(id);
        if (!occ_m[id]) begin
            push(1, 3);
            tick();
            exit = 1'b0;
            check_eq("absent_ready", 32'(ready), 32'd1);
            return;
        end
        tick();
        exit = 1'b0;
        d = mtime - tin_m[id];
        push(2, fee(int'(d), 2, 12));
        occ_m[id] = 1'b0;
        cnt_m--;
        check_eq("exit_busy", 32'(ready), 32'd0);
        tick();
        check_eq("exit_count", 32'(cars_count), 32'(cnt_m));
        check_eq("exit_ack_early", 32'(exit_ack), 32'd0);
        tick();
        check_eq("exit_ack", 32'(exit_ack), 32'd1);
        check_eq("exit_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        logic [TIME_W-1:0] t0;
        logic [TIME_W-1:0] sd;

        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        check_eq("rst_count", 32'(cars_count), 32'd0);
        check_eq("rst_empty", 32'(is_empty), 32'd1);
        check_eq("rst_full", 32'(is_full), 32'd0);
        check_eq("rst_ccost", 32'(ccost), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_time", 32'(current_time), 32'(mtime));

        // Basic stay: 5 -> 12
        wait_time(8'd5);
        do_entry(2);
        wait_time(8'd12);
        do_exit(2);
        check_eq("basic_empty", 32'(is_empty), 32'd1);
        check_eq("time_track", 32'(current_time), 32'(mtime));

        // Fill back-to-back, then full and duplicate rejections
        for (int i = 0; i < 4; i++) do_entry(i);
        check_eq("fill_full", 32'(is_full), 32'd1);
        check_eq("fill_empty", 32'(is_empty), 32'd0);
        do_entry(5);
        do_entry(1);
        check_eq("fill_count", 32'(cars_count), 32'd4);
        t0 = mtime + 8'd3;
        wait_time(t0);
        for (int i = 0; i < 4; i++) do_exit(i);

        // Wrap-around duration 250 -> 4
        wait_time(8'd250);
        do_entry(4);
        wait_time(8'd4);
        do_exit(4);
        do_exit(6);
        entry  = 1'b1;
        exit   = 1'b1;
        car_id = 3'd2;
        push(1, 0);
        tick();
        entry = 1'b0;
        exit  = 1'b0;
        check_eq("conflict_ready", 32'(ready), 32'd1);

        // Same-tick exit hits the minimum fee; requests while busy are ignored
        t0 = mtime + 8'd1;
        wait_time(t0);
        do_entry(7);
        exit   = 1'b1;
        car_id = 3'd7;
        tick();
        exit   = 1'b0;
        push(2, fee(int'(8'(mtime - tin_m[7])), 2, 12));
        occ_m[7] = 1'b0;
        cnt_m--;
        entry  = 1'b1;
        car_id = 3'd3;
        tick();
        tick();
        entry = 1'b0;
        check_eq("busy_ignored", 32'(cars_count), 32'd0);
        check_eq("min_fee", 32'(ccost), 32'd1);

        // Saturating tariff on the second instance
        t0 = mtime + 8'd1;
        wait_time(t0);
        s_entry = 1'b1;
        s_id    = 3'd3;
        t0      = mtime;
        tick();
        s_entry = 1'b0;
        check_eq("sat_entry_ack", 32'(s_entry_ack), 32'd1);
        wait_time(t0 + 8'd10);
        s_exit = 1'b1;
        tick();
        s_exit = 1'b0;
        sd = mtime - t0;
        tick();
        tick();
        check_eq("sat_valid", 32'(s_cost_valid), 32'd1);
        check_eq("sat_ccost", 32'(s_ccost), 32'(fee(int'(sd), 100, 8)));
        check_eq("sat_ccost_abs", 32'(s_ccost), 32'd255);

        // Reset during EXIT_RD abandons the exit
        do_entry(5);
        exit   = 1'b1;
        car_id = 3'd5;
        tick();
        exit  = 1'b0;
        reset = 1'b1;
        tick();
        occ_m = '0;
        cnt_m = 0;
        check_eq("rrd_exit_ack", 32'(exit_ack), 32'd0);
        check_eq("rrd_ccost", 32'(ccost), 32'd0);
        check_eq("rrd_count", 32'(cars_count), 32'd0);
        check_eq("rrd_ready", 32'(ready), 32'd1);
        reset = 1'b0;
        repeat (4) tick();
        check_eq("rrd_after_ack", 32'(exit_ack), 32'd0);
        check_eq("rrd_after_valid", 32'(cost_valid), 32'd0);

        repeat (2) tick();
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
